// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with dead time and leading-zero suppression.
// Define SEG_SCAN_HEX_DECODE_EN to display codes 10..15 as A b C d E F.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYCLES    = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

    // Active-high {a,b,c,d,e,f,g,dp} pattern with dp cleared.
    function automatic logic [7:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 8'hFC;
            4'h1:    decode = 8'h60;
            4'h2:    decode = 8'hDA;
            4'h3:    decode = 8'hF2;
            4'h4:    decode = 8'h66;
            4'h5:    decode = 8'hB6;
            4'h6:    decode = 8'hBE;
            4'h7:    decode = 8'hE0;
            4'h8:    decode = 8'hFE;
            4'h9:    decode = 8'hF6;
`ifdef SEG_SCAN_HEX_DECODE_EN
            4'hA:    decode = 8'hEE;
            4'hB:    decode = 8'h3E;
            4'hC:    decode = 8'h9C;
            4'hD:    decode = 8'h7A;
            4'hE:    decode = 8'h9E;
            default: decode = 8'h8E;
`else
            default: decode = 8'h00;
`endif
        endcase
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_lz;

    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_sup;
    logic [3:0]              cur_code;
    logic [7:0]              seg_val;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_hot;
    logic [NUM_DIGITS-1:0]   an_next;

    // Walk from the most significant digit down; a blanked digit reads as zero.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run && ((snap_digits[4*i +: 4] == 4'h0) || snap_blank[i]);
            lz_sup[i] = snap_lz && zero_run && (i != 0);
        end
    end

    always_comb begin
        cur_code = snap_digits[int'(idx)*4 +: 4];
        seg_val  = (snap_blank[idx] || lz_sup[idx]) ? 8'h00 : decode(cur_code);
        seg_val[0] = snap_dp[idx];
        an_hot      = '0;
        an_hot[idx] = 1'b1;

        if ((DEAD_CYCLES != 0) && (cnt < DEAD_END)) begin
            seg_next = SEG_OFF;
            an_next  = AN_OFF;
        end else begin
            seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_val : seg_val;
            an_next  = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            SEG         <= SEG_OFF;
            AN          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge cnt/idx.
            SEG         <= seg_next;
            AN          <= an_next;
            frame_start <= (cnt == '0) && (idx == '0);

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx         <= '0;
                    snap_digits <= digits;
                    snap_dp     <= dp;
                    snap_blank  <= blank;
                    snap_lz     <= lz_en;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2,
// one active-high SEG instance and one active-low SEG instance on shared inputs.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [7:0]  seg, seg_i;
    logic [3:0]  an, an_i;
    logic        fs, fs_i;

    int checks   = 0;
    int failures = 0;
    int wait_cycles;

    logic [7:0] seg_log  [32];
    logic [7:0] segi_log [32];
    logic [3:0] an_log   [32];
    logic       fs_log   [32];
    logic [7:0] exp_seg  [4];

`ifdef SEG_SCAN_HEX_DECODE_EN
    localparam logic [7:0] HEX_B = 8'h3E;
`else
    localparam logic [7:0] HEX_B = 8'h00;
`endif

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank), .lz_en(lz_en),
        .SEG(seg), .AN(an), .frame_start(fs)
    );

    seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) u_inv (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank(blank), .lz_en(lz_en),
        .SEG(seg_i), .AN(an_i), .frame_start(fs_i)
    );

    // Expected values for sample k of a frame (k=0 is the frame_start cycle).
    function automatic logic [3:0] exp_an(input int k);
        return ((k % 8) < 2) ? 4'hF : ~(4'b0001 << (k / 8));
    endfunction

    function automatic logic [7:0] exp_s(input int k);
        return ((k % 8) < 2) ? 8'h00 : exp_seg[k / 8];
    endfunction

    // Records one frame of outputs starting at the next frame_start; optionally
    // changes digits right after sample chg_k.
    task automatic capture(input int chg_k, input logic [15:0] chg_val);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs !== 1'b1 && n < 100);
        wait_cycles = n;
        checks++;
        if (fs !== 1'b1) begin
            failures++;
            $display("FAIL frame_timeout waited=%0d cycles got frame_start=%b want 1", n, fs);
        end
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            seg_log[k]  = seg;
            segi_log[k] = seg_i;
            an_log[k]   = an;
            fs_log[k]   = fs;
            if (k == chg_k) digits = chg_val;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        digits = 16'h1234;
        dp     = 4'b0000;
        blank  = 4'b0000;
        lz_en  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (seg !== 8'h00 || an !== 4'hF || fs !== 1'b0 || seg_i !== 8'hFF || an_i !== 4'hF) begin
            failures++;
            $display("FAIL reset_state got seg=%h an=%b fs=%b seg_inv=%h want 00 1111 0 FF",
                     seg, an, fs, seg_i);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        capture(-1, 16'h0);
        exp_seg = '{8'hFC, 8'hFC, 8'hFC, 8'hFC};
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k)) begin
                failures++;
                $display("FAIL post_reset_frame k=%0d got seg=%h an=%b want seg=%h an=%b",
                         k, seg_log[k], an_log[k], exp_s(k), exp_an(k));
            end
        end
        capture(-1, 16'h0);
        exp_seg = '{8'h66, 8'hF2, 8'hDA, 8'h60};
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k) || fs_log[k] !== (k == 0)) begin
                failures++;
                $display("FAIL scan_order k=%0d got seg=%h an=%b fs=%b want seg=%h an=%b fs=%b",
                         k, seg_log[k], an_log[k], fs_log[k], exp_s(k), exp_an(k), k == 0);
            end
        end
        capture(-1, 16'h0);
        checks++;
        if (wait_cycles != 1) begin
            failures++;
            $display("FAIL frame_period got %0d want 32 cycles", 31 + wait_cycles);
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vec [3]  = '{16'h0070, 16'h0000, 16'h0500};
        logic [3:0]  blk [3]  = '{4'b0000, 4'b0000, 4'b0100};
        logic [7:0]  want[12] = '{8'hFC, 8'hE0, 8'h00, 8'h00,
                                  8'hFC, 8'h00, 8'h00, 8'h00,
                                  8'hFC, 8'h00, 8'h00, 8'h00};
        lz_en = 1'b1;
        for (int v = 0; v < 3; v++) begin
            digits = vec[v];
            blank  = blk[v];
            capture(-1, 16'h0);
            capture(-1, 16'h0);
            for (int d = 0; d < 4; d++) exp_seg[d] = want[4*v + d];
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k)) begin
                    failures++;
                    $display("FAIL leading_zero digits=%h k=%0d got seg=%h an=%b want seg=%h an=%b",
                             vec[v], k, seg_log[k], an_log[k], exp_s(k), exp_an(k));
                end
            end
        end
        lz_en = 1'b0;
        blank = 4'b0000;
    endtask

    task automatic test_tear_free();
        digits = 16'h1234;
        capture(-1, 16'h0);
        capture(10, 16'h5678);
        exp_seg = '{8'h66, 8'hF2, 8'hDA, 8'h60};
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k)) begin
                failures++;
                $display("FAIL tear_free_old k=%0d got seg=%h an=%b want seg=%h an=%b",
                         k, seg_log[k], an_log[k], exp_s(k), exp_an(k));
            end
        end
        capture(-1, 16'h0);
        exp_seg = '{8'hFE, 8'hE0, 8'hBE, 8'hB6};
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k)) begin
                failures++;
                $display("FAIL tear_free_new k=%0d got seg=%h an=%b want seg=%h an=%b",
                         k, seg_log[k], an_log[k], exp_s(k), exp_an(k));
            end
        end
    endtask

    task automatic test_dp_blank_polarity();
        logic [3:0] dps  [2] = '{4'b0100, 4'b0001};
        logic [7:0] want [8] = '{8'h00, 8'hF2, 8'hDB, 8'h60,
                                 8'h01, 8'hF2, 8'hDA, 8'h60};
        digits = 16'h1234;
        blank  = 4'b0001;
        for (int v = 0; v < 2; v++) begin
            dp = dps[v];
            capture(-1, 16'h0);
            capture(-1, 16'h0);
            for (int d = 0; d < 4; d++) exp_seg[d] = want[4*v + d];
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (seg_log[k] !== exp_s(k) || segi_log[k] !== ~exp_s(k) || an_log[k] !== exp_an(k)) begin
                    failures++;
                    $display("FAIL dp_blank dp=%b k=%0d got seg=%h seg_inv=%h an=%b want %h %h %b",
                             dps[v], k, seg_log[k], segi_log[k], an_log[k],
                             exp_s(k), ~exp_s(k), exp_an(k));
                end
            end
        end
        dp    = 4'b0000;
        blank = 4'b0000;
    endtask

    task automatic test_hex_reset();
        digits = 16'h0B00;
        lz_en  = 1'b1;
        capture(-1, 16'h0);
        capture(-1, 16'h0);
        exp_seg = '{8'hFC, 8'hFC, HEX_B, 8'h00};
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k)) begin
                failures++;
                $display("FAIL hex_digit k=%0d got seg=%h an=%b want seg=%h an=%b",
                         k, seg_log[k], an_log[k], exp_s(k), exp_an(k));
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (an !== 4'b1110) begin
            failures++;
            $display("FAIL pre_reset_active got an=%b want 1110", an);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 8'h00 || an !== 4'hF || fs !== 1'b0 || seg_i !== 8'hFF) begin
            failures++;
            $display("FAIL async_reset got seg=%h an=%b fs=%b seg_inv=%h want 00 1111 0 FF",
                     seg, an, fs, seg_i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(-1, 16'h0);
        checks++;
        if (wait_cycles != 1) begin
            failures++;
            $display("FAIL restart_latency got %0d cycles want 1", wait_cycles);
        end
        exp_seg = '{8'hFC, 8'hFC, 8'hFC, 8'hFC};
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (seg_log[k] !== exp_s(k) || an_log[k] !== exp_an(k)) begin
                failures++;
                $display("FAIL restart_frame k=%0d got seg=%h an=%b want seg=%h an=%b",
                         k, seg_log[k], an_log[k], exp_s(k), exp_an(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_tear_free();
        test_dp_blank_polarity();
        test_hex_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
